// File: rtl/calc_seq_pkg.sv
// rtl/calc_seq_pkg.sv - shared widths, FSM state type and helpers for the calculator job sequencer
package calc_seq_pkg;

  localparam int CMD_W = 14;
  localparam int RES_W = 4;
  localparam int SEQ_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // Saturating increment used for the completed-job counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/calc_job_sequencer_if.sv
// rtl/calc_job_sequencer_if.sv - command and result handshake bundle of the job sequencer
interface calc_job_sequencer_if;
  import calc_seq_pkg::*;

  logic             cmd_valid;
  logic [CMD_W-1:0] cmd_word;
  logic             cmd_ready;
  logic             flush;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic [SEQ_W-1:0] res_seq;
  logic             res_ready;

  // Command producer and result consumer side.
  modport master (
    output cmd_valid, cmd_word, flush, res_ready,
    input  cmd_ready, res_valid, res_data, res_seq
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_word, flush, res_ready,
    output cmd_ready, res_valid, res_data, res_seq
  );

endinterface

// File: rtl/calc_cmd_fifo.sv
// rtl/calc_cmd_fifo.sv - synchronous command word queue with flush
module calc_cmd_fifo
  import calc_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [CMD_W-1:0] wr_data,
  output logic [CMD_W-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/calc_job_sequencer.sv
// rtl/calc_job_sequencer.sv - queues command words and sequences them through the calculator datapath
module calc_job_sequencer
  import calc_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  calc_job_sequencer_if.slave  bus,
  output logic [CMD_W-1:0]     calc_string,
  input  logic [RES_W-1:0]     calc_res,
  output logic                 busy,
  output logic [CNT_W-1:0]     job_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic [SEQ_W-1:0] seq;
  logic             pop;
  logic             capture;
  logic             retire;
  logic [CMD_W-1:0] head_word;
  logic             q_full;
  logic             q_empty;
  logic [AW:0]      q_count;

  calc_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.cmd_valid),
    .pop     (pop),
    .flush   (bus.flush),
    .wr_data (bus.cmd_word),
    .rd_data (head_word),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign bus.cmd_ready = !q_full;
  assign busy          = (state != IDLE) || (q_count != '0);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle strobes: pop a word, capture its result, retire on handshake.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop        = 1'b1;
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          retire     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath drive, settle timer, result capture and job bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calc_string   <= '0;
      cnt           <= '0;
      seq           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_seq   <= '0;
      job_count     <= '0;
    end else begin
      if (pop) begin
        calc_string <= head_word;
        cnt         <= CW'(SETTLE_CYC - 1);
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        bus.res_data  <= calc_res;
        bus.res_seq   <= seq;
        bus.res_valid <= 1'b1;
      end
      if (retire) begin
        bus.res_valid <= 1'b0;
        seq           <= seq + 1'b1;
        job_count     <= sat_inc(job_count);
      end
    end
  end

endmodule

// File: tb/tb_calc_job_sequencer.sv
// tb/tb_calc_job_sequencer.sv - scoreboard bench for the calculator job sequencer
module tb_calc_job_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] calc_string;
  logic [3:0]  calc_res;
  logic        busy;
  logic [7:0]  job_count;

  calc_job_sequencer_if bus();

  calc_job_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYC(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .calc_string (calc_string),
    .calc_res    (calc_res),
    .busy        (busy),
    .job_count   (job_count)
  );

  always #5 clk = ~clk;

  // Stand-in combinational calculator: nibble arithmetic on the command word.
  function automatic logic [3:0] calc_model(input logic [13:0] w);
    return w[11:8] + w[7:4] - w[13:10];
  endfunction

  assign calc_res = calc_model(calc_string);

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done = 0;
  int zero_seq = 0;
  int acc_n = 0;
  logic [3:0] sb[$];
  int rise_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop the expected result when a new result appears, then watch it stay stable.
  logic       held = 1'b0;
  logic       prev_valid = 1'b0;
  logic [3:0] held_data;
  logic [3:0] held_seq;
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
      prev_valid = 1'b0;
      done = 0;
      zero_seq = 0;
    end else begin
      if (bus.res_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = bus.res_valid;
      if (bus.res_valid) begin
        if (!held) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=data %0h seq %0h required=none", bus.res_data, bus.res_seq);
          end else begin
            logic [3:0] exp_d;
            exp_d = sb.pop_front();
            check("res_data", 32'(bus.res_data), 32'(exp_d));
            check("res_seq", 32'(bus.res_seq), 32'(done % 16));
            if (done % 16 == 0) zero_seq++;
          end
          held = 1'b1;
          held_data = bus.res_data;
          held_seq = bus.res_seq;
        end else begin
          check("hold_data_stable", 32'(bus.res_data), 32'(held_data));
          check("hold_seq_stable", 32'(bus.res_seq), 32'(held_seq));
        end
        if (bus.res_ready) begin
          held = 1'b0;
          done++;
        end
      end
    end
  end

  // Offer one word for one cycle; called at posedge+1, returns at the next posedge+1.
  task automatic offer(input logic [13:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_word = w;
    if (bus.cmd_ready && !bus.flush) begin
      acc_n++;
      sb.push_back(calc_model(w));
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (done < n) begin
      checks++;
      errors++;
      $display("FAIL timeout_done actual=%0d required=%0d", done, n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!bus.res_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.res_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout_res_valid actual=0 required=1");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [13:0] w;
    logic [13:0] cs;
    logic stable;
    int k;
    bus.cmd_word = '0;
    reset = 1'b1;
    #1;
    apply_reset();

    // Reset state
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_calc_string", 32'(calc_string), 0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_job_count", 32'(job_count), 0);
    check("rst_res_seq", 32'(bus.res_seq), 0);
    check("rst_res_data", 32'(bus.res_data), 0);

    // Single job with latency checks
    w = 14'b00011000100010;
    offer(w);
    check("single_busy", 32'(busy), 1);
    @(posedge clk); #1;
    check("single_calc_string", 32'(calc_string), 32'(w));
    repeat (2) @(posedge clk); #1;
    check("single_valid_early", 32'(bus.res_valid), 0);
    @(posedge clk); #1;
    check("single_valid_latency", 32'(bus.res_valid), 1);
    check("single_res_data", 32'(bus.res_data), 32'h7);
    check("single_res_seq", 32'(bus.res_seq), 0);
    repeat (3) @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("single_valid_cleared", 32'(bus.res_valid), 0);
    check("single_job_count", 32'(job_count), 1);

    // Back-to-back with res_ready held high
    apply_reset();
    bus.res_ready = 1'b1;
    rise_q.delete();
    for (int i = 0; i < 3; i++) offer(14'($urandom_range(0, 16383)));
    wait_done(3, 100);
    check("b2b_results", 32'(rise_q.size()), 3);
    if (rise_q.size() == 3) begin
      check("b2b_spacing_01", 32'(rise_q[1] - rise_q[0]), 5);
      check("b2b_spacing_12", 32'(rise_q[2] - rise_q[1]), 5);
    end
    check("b2b_job_count", 32'(job_count), 3);

    // Full queue under back-pressure
    apply_reset();
    acc_n = 0;
    for (int i = 0; i < 7; i++) offer(14'($urandom_range(0, 16383)));
    check("full_accepted", 32'(acc_n), 5);
    check("full_cmd_ready", 32'(bus.cmd_ready), 0);
    cs = calc_string;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (calc_string !== cs) stable = 1'b0;
    end
    check("full_calc_string_stable", 32'(stable), 1);
    bus.res_ready = 1'b1;
    wait_done(5, 200);
    bus.res_ready = 1'b0;
    check("full_job_count", 32'(job_count), 5);
    check("full_drained_busy", 32'(busy), 0);

    // Flush during SETTLE of job 0
    apply_reset();
    for (int i = 0; i < 3; i++) offer(14'($urandom_range(0, 16383)));
    bus.flush = 1'b1;
    while (sb.size() > 1) void'(sb.pop_back());
    @(posedge clk); #1;
    bus.flush = 1'b0;
    wait_valid(20);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("flush_busy", 32'(busy), 0);
    check("flush_job_count", 32'(job_count), 1);
    bus.res_ready = 1'b1;
    repeat (15) @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("flush_no_more", 32'(done), 1);

    // Reset mid-HOLD
    apply_reset();
    bus.res_ready = 1'b1;
    offer(14'($urandom_range(0, 16383)));
    wait_done(1, 50);
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(14'($urandom_range(0, 16383)));
    wait_valid(20);
    #1 reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_res_valid", 32'(bus.res_valid), 0);
    check("midrst_calc_string", 32'(calc_string), 0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("midrst_job_count", 32'(job_count), 0);
    check("midrst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.res_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("midrst_no_results", 32'(bus.res_valid), 0);
    check("midrst_done", 32'(done), 0);

    // Wrap and saturate over 260 randomly spaced jobs
    apply_reset();
    bus.res_ready = 1'b1;
    acc_n = 0;
    k = 0;
    while (acc_n < 260 && k < 5000) begin
      if ($urandom_range(0, 3) != 0) offer(14'($urandom_range(0, 16383)));
      else begin
        @(posedge clk); #1;
      end
      k++;
    end
    check("wrap_accepted", 32'(acc_n), 260);
    wait_done(260, 3000);
    check("wrap_job_count_sat", 32'(job_count), 255);
    check("wrap_seq_zero_count", 32'(zero_seq), 17);
    check("wrap_done", 32'(done), 260);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_job_sequencer.md
# calc_job_sequencer

Sequencer that sits in front of the combinational `Calculator` datapath and lets the calculator serve a stream of 14-bit command words. It queues incoming words and drives one word at a time onto the calculator's `string` input. It waits a programmable settle time, captures the 4-bit `res`, and returns it through a valid/ready result port tagged with a sequence number. It replaces bench-style "apply, wait, sample" stimulus with a synthesizable, back-pressured front end.

## Interface
- `FIFO_DEPTH`, 4: command queue entries; power of two, ≥2.
- `SETTLE_CYC`, 3: cycles a word is held on `calc_string` before `calc_res` is sampled; ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command word offered.
- `cmd_word`  in  14  command word, same encoding as the calculator `string` input.
- `cmd_ready`  out  1  queue can accept a word.
- `flush`  in  1  synchronous; empties the queue.
- `calc_string`  out  14  registered drive to the calculator `string` input.
- `calc_res`  in  4  calculator `res` output.
- `res_valid`  out  1  captured result available.
- `res_data`  out  4  captured result.
- `res_seq`  out  4  sequence tag of the result; wraps 15→0.
- `res_ready`  in  1  result consumer ready.
- `busy`  out  1  FSM not IDLE or queue non-empty.
- `job_count`  out  8  completed jobs; saturates at 255.

## Operation
- Push:
  - A word is accepted when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`, decoded from the registered occupancy count.
  - A push while full is dropped silently; the source must honour `cmd_ready`.
  - `cmd_ready` stays low while full, even if a pop occurs in the same cycle.
- FSM states: IDLE, SETTLE, HOLD.
  - **IDLE:** if the queue is non-empty, pop the head into `calc_string`, load `cnt = SETTLE_CYC-1`, go to SETTLE.
  - **SETTLE:** if `cnt != 0`, decrement. If `cnt == 0`, register `res_data <= calc_res` and `res_seq <= seq`, set `res_valid`, go to HOLD.
  - **HOLD:** hold `res_valid`, `res_data` and `res_seq` stable until `res_ready`. On the handshake edge, clear `res_valid`, increment `seq` (mod 16), increment `job_count` (saturating), go to IDLE.
- `calc_string` changes only on a pop. It holds the last word while IDLE and HOLD, so the datapath never glitches.
- `flush`:
  - Resets the queue pointers and count in the same cycle.
  - It does not abort the job in SETTLE or HOLD, which completes normally.
  - A push in the same cycle as `flush` is discarded.
- Simultaneous push and pop on a non-full queue: both take effect; the count is unchanged.
- Reset (any time, including mid-job):
  - `calc_string=0`, `res_valid=0`, `res_data=0`, `res_seq=0`, `seq=0`, `job_count=0`.
  - Queue emptied, FSM in IDLE, so `cmd_ready=1` and `busy=0`.
  - In-flight and queued jobs are discarded.

## Timing
- Push accepted at edge E0 into an empty queue with the FSM in IDLE:
  - E1: pop; `calc_string` shows the new word after E1.
  - E(1+SETTLE_CYC): sample `calc_res`; `res_valid` visible after this edge.
  - Latency is SETTLE_CYC+1 cycles; with default parameters, `res_valid` is seen 4 cycles after the push.
- With `res_ready` held high, the handshake occurs one cycle after `res_valid` rises. The next pop follows one cycle after that, so throughput is 1 job per SETTLE_CYC+2 cycles.
- `calc_res` is sampled after exactly SETTLE_CYC full cycles of a stable `calc_string`.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from registers only (no input-to-output combinational path).

## Structure
- Package `calc_seq_pkg`:
  - `CMD_W=14`, `RES_W=4`, `SEQ_W=4`, `CNT_W=8`.
  - FSM state enum `{IDLE, SETTLE, HOLD}`.
- Sub-module `calc_cmd_fifo`:
  - Synchronous FIFO, `FIFO_DEPTH` × `CMD_W`.
  - Ports: push, pop, flush, full, empty, count.
  - Async active-high reset.
- Top level contains the FSM, settle counter, capture registers and counters.

## Test plan
- **Single job:** reset, then push `14'b00011000100010`; the calculator model returns `4'h7`. Expect `calc_string` equal to the word after E1, `res_valid` high 4 cycles after the push, `res_data=7`, `res_seq=0`, then `job_count=1` after the handshake.
- **Back-to-back:** `res_ready=1`, push 3 words in consecutive cycles. Expect results in order with `res_seq` 0, 1, 2, rising edges of `res_valid` 5 cycles apart, and `job_count=3`.
- **Full queue:** `res_ready=0`, offer 7 words in consecutive cycles. Expect exactly 5 accepted (1 in flight + 4 queued), `cmd_ready` low afterwards, and `res_data`/`res_seq`/`calc_string` stable for 20 cycles.
- **Flush:** 3 words queued, assert `flush` during SETTLE of job 0. Expect job 0 to complete with `res_seq=0`, no further `res_valid`, `busy=0` after the handshake, and `job_count=1`.
- **Reset mid-HOLD:** assert `reset` asynchronously with `res_valid=1` and 2 words queued. Expect `res_valid=0`, `calc_string=0`, `cmd_ready=1`, `job_count=0` before the next clock edge, and no results after reset is released.
- **Wrap/saturate:** run 260 jobs with `res_ready=1`. Expect `res_seq` to wrap 15→0 repeatedly and `job_count` to hold at 255.
